// File: rtl/wb_stage.sv
// Writeback stage: latches the memory-stage result, drives the regfile/forwarding bus,
// commits exceptions/ertn with the exception CSRs. Optional trace outputs: WB_DEBUG_TRACE_EN.
module wb_stage #(
    parameter logic [31:0] EENTRY_RST = 32'h0000_0000,
    parameter logic [31:0] CRMD_RST   = 32'h0000_0008
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ws_allowin,
    input  logic        ms_to_ws_valid,
    input  logic [37:0] ms_rf_collect,
    input  logic [31:0] ms_pc,
    input  logic [6:0]  ms_to_ws_bus,
    input  logic [78:0] ms_csr_bus,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [37:0] ws_fwd_bus,
    output logic        wb_flush,
    output logic [31:0] wb_redirect_pc,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    logic        ws_valid;
    logic        ws_ready_go;
    logic [37:0] ws_collect;
    logic [31:0] ws_pc;
    logic [6:0]  ws_flags;
    logic [78:0] ws_csr;

    logic        ex;
    logic        ertn;
    logic [5:0]  ecode;

    logic        csr_wr;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;

    logic [31:0] crmd, prmd, estat, era, eentry;
    logic [31:0] save [4];

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = ~ws_valid | ws_ready_go;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (wb_flush) begin
            ws_valid <= 1'b0;
        end else begin
            ws_valid <= ms_to_ws_valid & ws_allowin;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_collect <= '0;
            ws_pc      <= '0;
            ws_flags   <= '0;
            ws_csr     <= '0;
        end else if (ms_to_ws_valid & ws_allowin & ~wb_flush) begin
            ws_collect <= ms_rf_collect;
            ws_pc      <= ms_pc;
            ws_flags   <= ms_to_ws_bus;
            ws_csr     <= ms_csr_bus;
        end
    end

    assign ex       = ws_valid & (|ws_flags[5:0]);
    assign ertn     = ws_valid & ws_flags[6] & ~ex;
    assign wb_flush = ex | ertn;

    assign rf_we      = ws_valid & ws_collect[37] & ~ex;
    assign rf_waddr   = ws_collect[36:32];
    assign rf_wdata   = ws_collect[31:0];
    assign ws_fwd_bus = {rf_we, rf_waddr, rf_wdata};

    always_comb begin
        wb_redirect_pc = '0;
        if (ex)        wb_redirect_pc = eentry;
        else if (ertn) wb_redirect_pc = era;
    end

    // flags = {ertn, syscall, brk, ine, ale, adef, int}; ordered by commit priority
    always_comb begin
        ecode = 6'h09;
        if      (ws_flags[0]) ecode = 6'h00;
        else if (ws_flags[1]) ecode = 6'h08;
        else if (ws_flags[3]) ecode = 6'h0D;
        else if (ws_flags[5]) ecode = 6'h0B;
        else if (ws_flags[4]) ecode = 6'h0C;
    end

    assign {csr_wr, csr_num, csr_wmask, csr_wvalue} = {ws_valid & ws_csr[78] & ~ex, ws_csr[77:0]};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] field,
                                          input logic [31:0] wmask, input logic [31:0] wvalue);
        logic [31:0] m;
        m = wmask & field;
        return (old & ~m) | (wvalue & m);
    endfunction

    // ertn's CRMD restore is written last so it overrides a same-cycle CRMD write
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd   <= CRMD_RST;
            prmd   <= '0;
            estat  <= '0;
            era    <= '0;
            eentry <= EENTRY_RST;
            for (int unsigned i = 0; i < 4; i++) save[i] <= '0;
        end else begin
            if (csr_wr) begin
                case (csr_num)
                    14'h000: crmd   <= merge(crmd,   32'h0000_0007, csr_wmask, csr_wvalue);
                    14'h001: prmd   <= merge(prmd,   32'h0000_0007, csr_wmask, csr_wvalue);
                    14'h005: estat  <= merge(estat,  32'h0000_0003, csr_wmask, csr_wvalue);
                    14'h006: era    <= merge(era,    32'hFFFF_FFFF, csr_wmask, csr_wvalue);
                    14'h00C: eentry <= merge(eentry, 32'hFFFF_FFC0, csr_wmask, csr_wvalue);
                    14'h030: save[0] <= merge(save[0], 32'hFFFF_FFFF, csr_wmask, csr_wvalue);
                    14'h031: save[1] <= merge(save[1], 32'hFFFF_FFFF, csr_wmask, csr_wvalue);
                    14'h032: save[2] <= merge(save[2], 32'hFFFF_FFFF, csr_wmask, csr_wvalue);
                    14'h033: save[3] <= merge(save[3], 32'hFFFF_FFFF, csr_wmask, csr_wvalue);
                    default: ;
                endcase
            end
            if (ex) begin
                prmd[2:0]    <= crmd[2:0];
                crmd[2:0]    <= 3'b000;
                era          <= ws_pc;
                estat[21:16] <= ecode;
                estat[30:22] <= '0;
            end
            if (ertn) begin
                crmd[2:0] <= prmd[2:0];
            end
        end
    end

    always_comb begin
        csr_rvalue = '0;
        case (csr_rnum)
            14'h000: csr_rvalue = crmd;
            14'h001: csr_rvalue = prmd;
            14'h005: csr_rvalue = estat;
            14'h006: csr_rvalue = era;
            14'h00C: csr_rvalue = eentry;
            14'h030: csr_rvalue = save[0];
            14'h031: csr_rvalue = save[1];
            14'h032: csr_rvalue = save[2];
            14'h033: csr_rvalue = save[3];
            default: csr_rvalue = '0;
        endcase
    end

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
`else
    assign debug_wb_pc       = '0;
    assign debug_wb_rf_we    = '0;
    assign debug_wb_rf_wnum  = '0;
    assign debug_wb_rf_wdata = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios, then random traffic against a reference model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [37:0] ms_rf_collect;
    logic [31:0] ms_pc;
    logic [6:0]  ms_to_ws_bus;
    logic [78:0] ms_csr_bus;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [37:0] ws_fwd_bus;
    logic        wb_flush;
    logic [31:0] wb_redirect_pc;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rvalue;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    wb_stage #(.EENTRY_RST(32'h0000_0000), .CRMD_RST(32'h0000_0008)) dut (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_rf_collect(ms_rf_collect), .ms_pc(ms_pc),
        .ms_to_ws_bus(ms_to_ws_bus), .ms_csr_bus(ms_csr_bus),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .ws_fwd_bus(ws_fwd_bus),
        .wb_flush(wb_flush), .wb_redirect_pc(wb_redirect_pc),
        .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: instruction currently held in writeback plus CSRs indexed by number
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  flags;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        cwe;
        logic [13:0] cnum;
        logic [31:0] cmask;
        logic [31:0] cval;
    } inst_t;

    inst_t       m;
    logic [31:0] mcsr [64];

    function automatic logic [31:0] field_of(input logic [13:0] n);
        case (n)
            14'h000, 14'h001:                   return 32'h0000_0007;
            14'h005:                            return 32'h0000_0003;
            14'h006, 14'h030, 14'h031, 14'h032,
            14'h033:                            return 32'hFFFF_FFFF;
            14'h00C:                            return 32'hFFFF_FFC0;
            default:                            return 32'h0;
        endcase
    endfunction

    function automatic logic implemented(input logic [13:0] n);
        return n inside {14'h000, 14'h001, 14'h005, 14'h006, 14'h00C,
                         14'h030, 14'h031, 14'h032, 14'h033};
    endfunction

    function automatic logic m_ex();
        return m.valid && (m.flags[5:0] != 0);
    endfunction

    function automatic logic m_ertn();
        return m.valid && m.flags[6] && !m_ex();
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        foreach (mcsr[i]) mcsr[i] = 32'h0;
        mcsr[0]  = 32'h0000_0008;
        mcsr[12] = 32'h0000_0000;
    endtask

    task automatic model_update();
        logic [31:0] nx [64];
        int          bits  [6] = '{0, 1, 3, 5, 4, 2};
        int          codes [6] = '{'h0, 'h8, 'hD, 'hB, 'hC, 'h9};
        logic        flush;
        int          code;
        if (!resetn) begin
            model_reset();
            return;
        end
        nx = mcsr;
        flush = m_ex() || m_ertn();
        if (m.valid && m.cwe && !m_ex() && implemented(m.cnum))
            nx[m.cnum] = (mcsr[m.cnum] & ~(m.cmask & field_of(m.cnum)))
                       | (m.cval & m.cmask & field_of(m.cnum));
        if (m_ex()) begin
            code = -1;
            for (int k = 0; k < 6; k++)
                if (code < 0 && m.flags[bits[k]]) code = codes[k];
            nx[1][2:0]   = mcsr[0][2:0];
            nx[0][2:0]   = 3'b000;
            nx[6]        = m.pc;
            nx[5][21:16] = code[5:0];
            nx[5][30:22] = '0;
        end
        if (m_ertn()) nx[0][2:0] = mcsr[1][2:0];
        mcsr = nx;
        if (flush) m.valid = 1'b0;
        else       m.valid = ms_to_ws_valid;
        if (ms_to_ws_valid && !flush) begin
            m.pc    = ms_pc;
            m.flags = ms_to_ws_bus;
            {m.we, m.waddr, m.wdata} = ms_rf_collect;
            {m.cwe, m.cnum, m.cmask, m.cval} = ms_csr_bus;
        end
    endtask

    task automatic check_outputs();
        logic        e_we;
        logic        e_fl;
        logic [31:0] e_rd;
        e_we = m.valid && m.we && !m_ex();
        e_fl = m_ex() || m_ertn();
        e_rd = m_ex() ? mcsr[12] : (m_ertn() ? mcsr[6] : 32'h0);
        chk("allowin", ws_allowin, 1'b1);
        chk("rf_we", rf_we, e_we);
        chk("rf_waddr", rf_waddr, m.waddr);
        chk("rf_wdata", rf_wdata, m.wdata);
        chk("fwd_bus", ws_fwd_bus, {e_we, m.waddr, m.wdata});
        chk("flush", wb_flush, e_fl);
        chk("redirect", wb_redirect_pc, e_rd);
        chk("csr_rvalue", csr_rvalue,
            (csr_rnum < 64 && implemented(csr_rnum)) ? mcsr[csr_rnum[5:0]] : 32'h0);
`ifdef WB_DEBUG_TRACE_EN
        chk("dbg", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata},
            {m.pc, {4{e_we}}, m.waddr, m.wdata});
`else
        chk("dbg", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 64'h0);
`endif
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic issue(input logic v, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] pc, input logic [6:0] fl, input logic cwe,
                         input logic [13:0] cn, input logic [31:0] cm, input logic [31:0] cv);
        ms_to_ws_valid = v;
        ms_rf_collect  = {we, wa, wd};
        ms_pc          = pc;
        ms_to_ws_bus   = fl;
        ms_csr_bus     = {cwe, cn, cm, cv};
        tick();
    endtask

    task automatic bubble();
        issue(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 7'h0, 1'b0, 14'h0, 32'h0, 32'h0);
    endtask

    task automatic csr_write(input logic [13:0] cn, input logic [31:0] cm, input logic [31:0] cv);
        issue(1'b1, 1'b0, 5'd0, 32'h0, 32'h1c00_0000, 7'h0, 1'b1, cn, cm, cv);
    endtask

    task automatic rd(input string tag, input logic [13:0] n, input logic [31:0] exp);
        csr_rnum = n;
        #1;
        chk(tag, csr_rvalue, exp);
    endtask

    logic [13:0] nums [10] = '{14'h000, 14'h001, 14'h005, 14'h006, 14'h00C,
                               14'h030, 14'h031, 14'h032, 14'h033, 14'h007};

    initial begin
        resetn = 1'b0;
        csr_rnum = 14'h0;
        model_reset();
        bubble();
        bubble();
        resetn = 1'b1;
        rd("rst_crmd", 14'h000, 32'h0000_0008);
        rd("rst_eentry", 14'h00C, 32'h0);

        // normal write
        issue(1'b1, 1'b1, 5'd3, 32'h1234_5678, 32'h1c00_0010, 7'h0, 1'b0, 14'h0, 32'h0, 32'h0);
        chk("t1_we", rf_we, 1'b1);
        chk("t1_waddr", rf_waddr, 5'd3);
        chk("t1_wdata", rf_wdata, 32'h1234_5678);
        chk("t1_flush", wb_flush, 1'b0);

        // syscall
        csr_write(14'h000, 32'hFFFF_FFFF, 32'h0000_0007);
        csr_write(14'h00C, 32'hFFFF_FFFF, 32'h1c00_8000);
        issue(1'b1, 1'b1, 5'd4, 32'hDEAD_BEEF, 32'h1c00_0020, 7'b010_0000, 1'b0, 14'h0, 32'h0, 32'h0);
        chk("t2_flush", wb_flush, 1'b1);
        chk("t2_redirect", wb_redirect_pc, 32'h1c00_8000);
        chk("t2_we", rf_we, 1'b0);
        bubble();
        rd("t2_era", 14'h006, 32'h1c00_0020);
        rd("t2_estat", 14'h005, 32'h000B_0000);
        rd("t2_prmd", 14'h001, 32'h0000_0007);
        rd("t2_crmd", 14'h000, 32'h0000_0008);

        // ertn, then an instruction offered during the flush cycle is dropped
        csr_write(14'h006, 32'hFFFF_FFFF, 32'h1c00_0024);
        issue(1'b1, 1'b0, 5'd0, 32'h0, 32'h1c00_0030, 7'h40, 1'b0, 14'h0, 32'h0, 32'h0);
        chk("t3_flush", wb_flush, 1'b1);
        chk("t3_redirect", wb_redirect_pc, 32'h1c00_0024);
        issue(1'b1, 1'b1, 5'd7, 32'h5555_0000, 32'h1c00_0034, 7'h0, 1'b0, 14'h0, 32'h0, 32'h0);
        chk("t3_drop", rf_we, 1'b0);
        rd("t3_crmd", 14'h000, 32'h0000_000F);

        // masked CSR write
        csr_write(14'h030, 32'hFFFF_FFFF, 32'h1234_5678);
        csr_write(14'h030, 32'h0000_FFFF, 32'hAAAA_5555);
        bubble();
        rd("t4_save0", 14'h030, 32'h1234_5555);

        // adef + ale priority
        issue(1'b1, 1'b0, 5'd0, 32'h0, 32'h1c00_0040, 7'b000_0110, 1'b0, 14'h0, 32'h0, 32'h0);
        bubble();
        rd("t5_estat", 14'h005, 32'h0008_0000);
        rd("t5_era", 14'h006, 32'h1c00_0040);

        // reset while an exception sits in writeback
        issue(1'b1, 1'b1, 5'd9, 32'h1, 32'h1c00_0050, 7'b010_0000, 1'b0, 14'h0, 32'h0, 32'h0);
        resetn = 1'b0;
        issue(1'b1, 1'b1, 5'd9, 32'h1, 32'h1c00_0054, 7'b001_0000, 1'b0, 14'h0, 32'h0, 32'h0);
        chk("t6_we", rf_we, 1'b0);
        chk("t6_flush", wb_flush, 1'b0);
        chk("t6_redirect", wb_redirect_pc, 32'h0);
        rd("t6_crmd", 14'h000, 32'h0000_0008);
        rd("t6_eentry", 14'h00C, 32'h0);
        resetn = 1'b1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            logic [6:0]  fl;
            r = $urandom_range(0, 7);
            fl = (r < 5) ? 7'h0 : (r == 5) ? 7'(1 << $urandom_range(0, 6))
               : (r == 6) ? 7'($urandom) : 7'h40;
            resetn = ($urandom_range(0, 199) != 0);
            csr_rnum = ($urandom_range(0, 9) == 0) ? 14'($urandom) : nums[$urandom_range(0, 9)];
            issue($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), $urandom, $urandom, fl,
                  $urandom_range(0, 2) == 0, nums[$urandom_range(0, 9)],
                  ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
